gray_counter: RTL and testbench

- Registered up/down Gray-code counter.
- Sits directly upstream of the Gray-to-binary converter stage. Its Gray output feeds that stage, typically as a FIFO pointer that crosses to another domain before decoding.
- Keeps an internal binary count and registers the Gray encoding, so the Gray output changes exactly one bit per step and never glitches.
- Also provides the binary count, a terminal-count flag and a wrap pulse.

---
 rtl/gray_counter.sv | 69 ++++++
 tb/tb_gray_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter.
// A binary count is kept internally. The Gray output is encoded from the
// next binary value before the register, so dout moves one bit per enabled
// step and never glitches. dout can therefore be handed straight to
// another clock domain, for example as a FIFO pointer.
// Also provides the binary count, a terminal-count flag and a wrap pulse.
module gray_counter #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic [DW-1:0] din,
   input  logic          en,
   input  logic          up,
   output logic [DW-1:0] dout,
   output logic [DW-1:0] bin,
   output logic          tc,
   output logic          wrap
);

   localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};
   localparam logic [DW-1:0] ZERO     = {DW{1'b0}};
   localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};

   logic [DW-1:0] bin_next;
   logic [DW-1:0] gray_next;
   logic          step;
   logic          wrap_next;

   // tc flags that the next enabled step in the current direction wraps
   assign tc = (up & (bin == ALL_ONES)) | (~up & (bin == ZERO));

   // Next binary value with priority clr > load > en > hold; only a real count step may wrap
   always_comb begin
      bin_next  = bin;
      step      = 1'b0;
      wrap_next = 1'b0;
      if (clr) begin
         bin_next = ZERO;
      end else if (load) begin
         bin_next = din;
      end else if (en) begin
         step = 1'b1;
         if (up) begin
            bin_next = bin + ONE;
         end else begin
            bin_next = bin - ONE;
         end
      end
      wrap_next = step & tc;
      gray_next = bin_next ^ (bin_next >> 1);
   end

   // Register the binary count, its Gray encoding and the wrap pulse together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin  <= ZERO;
         dout <= ZERO;
         wrap <= 1'b0;
      end else begin
         bin  <= bin_next;
         dout <= gray_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter. Directed scenarios plus random
// traffic are checked against an arithmetic model of the counter.
module tb_gray_counter;

   localparam int DW   = 4;
   localparam int MODV = 1 << DW;
   localparam int MAXV = MODV - 1;

   logic          clk;
   logic          rst;
   logic          clr;
   logic          load;
   logic [DW-1:0] din;
   logic          en;
   logic          up;
   logic [DW-1:0] dout;
   logic [DW-1:0] bin;
   logic          tc;
   logic          wrap;

   gray_counter #(.DW(DW)) dut (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .load (load),
      .din  (din),
      .en   (en),
      .up   (up),
      .dout (dout),
      .bin  (bin),
      .tc   (tc),
      .wrap (wrap)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_bin  = 0;
   bit m_wrap = 0;

   // expected Gray sequence for the directed up-count run
   logic [DW-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic check_outputs(input string tag);
      int exp_tc;
      exp_tc = ((up == 1'b1) && (m_bin == MAXV)) || ((up == 1'b0) && (m_bin == 0)) ? 1 : 0;
      check_val({tag, ".bin"},  32'(bin),  32'(m_bin));
      check_val({tag, ".dout"}, 32'(dout), 32'(gray_of(m_bin)));
      check_val({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
      check_val({tag, ".tc"},   32'(tc),   32'(exp_tc));
   endtask

   // Drive one cycle of controls (called at a negedge), clock it, update the
   // model from the sampled controls and check at the following negedge.
   task automatic drive(input string tag, input bit c, input bit l, input int d,
                        input bit e, input bit u);
      logic [DW-1:0] prev_dout;
      int            raw;
      bit            is_step;
      clr  = c;
      load = l;
      din  = DW'(d);
      en   = e;
      up   = u;
      prev_dout = dout;
      @(posedge clk);
      is_step = 0;
      m_wrap  = 0;
      if (c) begin
         m_bin = 0;
      end else if (l) begin
         m_bin = d % MODV;
      end else if (e) begin
         is_step = 1;
         raw     = u ? m_bin + 1 : m_bin - 1;
         m_wrap  = (raw > MAXV) || (raw < 0);
         m_bin   = (raw + MODV) % MODV;
      end
      @(negedge clk);
      check_outputs(tag);
      if (is_step) check_val({tag, ".onebit"}, 32'($countones(dout ^ prev_dout)), 32'd1);
   endtask

   initial begin
      logic [DW-1:0] exp_g;
      rst = 1'b0; clr = 1'b0; load = 1'b0; din = '0; en = 1'b0; up = 1'b0;

      // reset between edges takes effect without a clock
      #1 rst = 1'b1;
      #1;
      check_val("rst_async.bin",  32'(bin),  32'd0);
      check_val("rst_async.dout", 32'(dout), 32'd0);
      check_val("rst_async.wrap", 32'(wrap), 32'd0);
      check_val("rst_async.tc",   32'(tc),   32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // hold with en=0
      for (int i = 0; i < 5; i++) drive("hold_dn", 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) drive("hold_up", 0, 0, 0, 0, 1);

      // full up count from 0
      exp_q = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      for (int i = 0; i < 16; i++) begin
         drive("up_cnt", 0, 0, 0, 1, 1);
         if (exp_q.size() > 0) begin
            exp_g = exp_q.pop_front();
            check_val("up_seq", 32'(dout), 32'(exp_g));
         end
      end

      // down from 0 wraps to F, then E
      drive("down_wrap", 0, 0, 0, 1, 0);
      check_val("down_wrap.bin_lit",  32'(bin),  32'hF);
      check_val("down_wrap.dout_lit", 32'(dout), 32'h8);
      check_val("down_wrap.wrap_lit", 32'(wrap), 32'd1);
      drive("down_next", 0, 0, 0, 1, 0);
      check_val("down_next.dout_lit", 32'(dout), 32'h9);

      // loads
      drive("load_a", 0, 1, 'hA, 0, 1);
      check_val("load_a.dout_lit", 32'(dout), 32'hF);
      drive("load_en", 0, 1, 3, 1, 1);
      check_val("load_en.bin_lit", 32'(bin), 32'h3);
      check_val("load_en.dout_lit", 32'(dout), 32'h2);

      // priority: clr beats load and en
      drive("load_f", 0, 1, 'hF, 0, 1);
      drive("clr_pri", 1, 1, 7, 1, 1);
      check_val("clr_pri.bin_lit", 32'(bin), 32'h0);
      drive("load_f2", 0, 1, 'hF, 0, 1);
      drive("load_zero", 0, 1, 0, 1, 1);
      check_val("load_zero.wrap_lit", 32'(wrap), 32'd0);
      drive("load_f3", 0, 1, 'hF, 0, 1);
      drive("clr_wrap", 1, 0, 0, 1, 1);

      // async reset mid-count at bin=9
      drive("load_9", 0, 1, 9, 0, 1);
      en = 1'b1; up = 1'b1; load = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_val("rst_mid.bin",  32'(bin),  32'd0);
      check_val("rst_mid.dout", 32'(dout), 32'd0);
      check_val("rst_mid.wrap", 32'(wrap), 32'd0);
      m_bin = 0; m_wrap = 0;
      @(negedge clk);
      rst = 1'b0;
      check_outputs("rst_held");
      drive("restart", 0, 0, 0, 1, 1);
      check_val("restart.dout_lit", 32'(dout), 32'h1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive("rand",
               ($urandom_range(15) == 0),
               ($urandom_range(7) == 0),
               int'($urandom_range(MAXV)),
               ($urandom_range(3) != 0),
               ($urandom_range(1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
